// File: rtl/key_filter_array.sv
`default_nettype none
// ============================================================================
// key_filter_array: N_CH-channel key debouncer (2-FF sync, press/release
// qualification, one-shot long-press).                       Revision 1.0
// ============================================================================
module key_filter_array #(
    parameter int N_CH     = 4,
    parameter int ACT_LOW  = 1,
    parameter int DEB_CNT  = 256,
    parameter int LONG_CNT = 50000
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            filt_en,
    input  logic [N_CH-1:0] key_in,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_release,
    output logic [N_CH-1:0] key_long,
    output logic            any_held
);
    localparam int CNT_W  = $clog2(DEB_CNT + 1);
    localparam int LCNT_W = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [N_CH-1:0]  SYNC_INIT = {N_CH{(ACT_LOW != 0)}};

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [N_CH-1:0] sync_ff1;
    logic [N_CH-1:0] sync_ff2;
    logic [N_CH-1:0] active;

    // Synchroniser resets to the idle key level so no false edge follows reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= SYNC_INIT;
            sync_ff2 <= SYNC_INIT;
        end else begin
            sync_ff1 <= key_in;
            sync_ff2 <= sync_ff1;
        end
    end

    assign active = (ACT_LOW != 0) ? ~sync_ff2 : sync_ff2;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            any_held <= 1'b0;
        end else begin
            any_held <= |key_level;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level;
        logic             level_nxt;
        logic             press;
        logic             press_nxt;
        logic             rel;
        logic             rel_nxt;
        logic             lcnt_clr;
        logic             lcnt_adv;

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                level <= level_nxt;
                press <= press_nxt;
                rel   <= rel_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            level_nxt = level;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            lcnt_clr  = 1'b0;
            lcnt_adv  = 1'b0;
            if (!filt_en) begin
                // Disable drops the key silently: no release pulse.
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
                lcnt_clr  = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (active[i]) begin
                            state_nxt = PRESS_CHK;
                            cnt_nxt   = CNT_W'(1);
                        end else begin
                            cnt_nxt = '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (!active[i]) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else if (cnt == DEB_LAST) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = '0;
                            level_nxt = 1'b1;
                            press_nxt = 1'b1;
                            lcnt_clr  = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!active[i]) begin
                            state_nxt = RELEASE_CHK;
                            cnt_nxt   = CNT_W'(1);
                        end else begin
                            lcnt_adv = 1'b1;
                        end
                    end
                    RELEASE_CHK: begin
                        // A release glitch keeps the long-press timer running.
                        lcnt_adv = 1'b1;
                        if (active[i]) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = '0;
                        end else if (cnt == DEB_LAST) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            level_nxt = 1'b0;
                            rel_nxt   = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                    end
                endcase
            end
        end

        assign key_level[i]   = level;
        assign key_press[i]   = press;
        assign key_release[i] = rel;

        if (LONG_CNT > 0) begin : g_long
            localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_CNT);
            localparam logic [LCNT_W-1:0] LCNT_FIRE = LCNT_W'(LONG_CNT - 1);
            logic [LCNT_W-1:0] lcnt;
            logic              long_done;
            logic              long_q;

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    lcnt      <= '0;
                    long_done <= 1'b0;
                    long_q    <= 1'b0;
                end else begin
                    long_q <= 1'b0;
                    if (lcnt_clr) begin
                        lcnt      <= '0;
                        long_done <= 1'b0;
                    end else if (lcnt_adv) begin
                        if (lcnt != LCNT_MAX) begin
                            lcnt <= lcnt + LCNT_W'(1);
                        end
                        if ((lcnt == LCNT_FIRE) && !long_done) begin
                            long_q    <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end
                end
            end

            assign key_long[i] = long_q;
        end else begin : g_no_long
            assign key_long[i] = 1'b0;
        end
    end

endmodule
`default_nettype wire
